// File: rtl/arb_pkg.sv
// Shared constants, state encoding and index helper for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [IDX_W-1:0] inc_mod_n(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N - 1)) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder: reports the lowest set bit of vec.
import arb_pkg::*;

module prio_enc8 (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  always_comb begin
    idx       = '0;
    any_valid = |vec;
    // Scan from the top so the lowest set bit is the last one written.
    for (int unsigned i = N; i > 0; i--) begin
      if (vec[i-1]) idx = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with hold-until-release grants and an
// optional hold-time limit that force-releases and pulses timeout.
import arb_pkg::*;

module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int unsigned HC_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HC_W-1:0]  hold_cnt;

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] k;
  logic             any_req;
  logic [IDX_W-1:0] winner;
  logic [N-1:0]     winner_oh;
  logic             hold_limit;
  logic             req_drop;
  logic             release_gnt;

  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      logic [IDX_W-1:0] src;
      src    = IDX_W'(i) + ptr;
      rot[i] = req[src];
    end
  end

  prio_enc8 u_enc (
    .vec       (rot),
    .idx       (k),
    .any_valid (any_req)
  );

  always_comb begin
    winner            = k + ptr;
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
    hold_limit        = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    req_drop          = ~req[gnt_idx];
    release_gnt       = done | req_drop | hold_limit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (any_req) begin
            gnt       <= winner_oh;
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_gnt) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= inc_mod_n(gnt_idx);
            // Only a release caused purely by the hold limit counts as a timeout.
            timeout   <= hold_limit & ~done & ~req_drop;
            state     <= IDLE;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
